// File: rtl/led_phase_sequencer.sv
// Three-phase LED sequencer (SOLID, SLOW blink, FAST blink) driven by a ms tick prescaler.
// Every output is a flop. Each state entry restarts the phase timing.
module led_phase_sequencer #(
  parameter int TICK_DIV  = 16000,
  parameter int P1_MS     = 1000,
  parameter int P2_MS     = 2000,
  parameter int P3_MS     = 1000,
  parameter int SLOW_HALF = 250,
  parameter int FAST_HALF = 62
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic       led,
  output logic       busy,
  output logic [1:0] phase,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOLID = 2'd1,
    SLOW  = 2'd2,
    FAST  = 2'd3
  } state_t;

  localparam int MAX_P12 = (P1_MS > P2_MS) ? P1_MS : P2_MS;
  localparam int MAX_P   = (MAX_P12 > P3_MS) ? MAX_P12 : P3_MS;
  localparam int MAX_H   = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int TW      = $clog2(TICK_DIV);
  localparam int MW      = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int HW      = (MAX_H > 1) ? $clog2(MAX_H) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [MW-1:0] P1_LAST   = MW'(P1_MS - 1);
  localparam logic [MW-1:0] P2_LAST   = MW'(P2_MS - 1);
  localparam logic [MW-1:0] P3_LAST   = MW'(P3_MS - 1);
  localparam logic [HW-1:0] SLOW_LAST = HW'(SLOW_HALF - 1);
  localparam logic [HW-1:0] FAST_LAST = HW'(FAST_HALF - 1);

  state_t        state, state_next;
  logic [TW-1:0] tick_cnt, tick_cnt_next;
  logic [MW-1:0] ms_cnt, ms_cnt_next;
  logic [HW-1:0] half_cnt, half_cnt_next;
  logic          led_next, busy_next, done_next;
  logic          tick, phase_last, phase_end, half_last, blinking;

  // NOTE: state registers use non-blocking assignments. That way every flop samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      ms_cnt   <= '0;
      half_cnt <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      ms_cnt   <= ms_cnt_next;
      half_cnt <= half_cnt_next;
      led      <= led_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  assign phase = state;

  // NOTE: every signal written below gets a default first, so no latch is inferred on any path.
  always_comb begin
    state_next    = state;
    done_next     = 1'b0;
    tick          = (tick_cnt == TICK_LAST);
    blinking      = (state == SLOW) || (state == FAST);
    tick_cnt_next = tick ? '0 : tick_cnt + 1'b1;
    ms_cnt_next   = tick ? ms_cnt + 1'b1 : ms_cnt;
    half_last     = (state == SLOW) ? (half_cnt == SLOW_LAST) : (half_cnt == FAST_LAST);
    half_cnt_next = half_cnt;
    led_next      = led;

    case (state)
      SOLID:   phase_last = (ms_cnt == P1_LAST);
      SLOW:    phase_last = (ms_cnt == P2_LAST);
      FAST:    phase_last = (ms_cnt == P3_LAST);
      default: phase_last = 1'b0;
    endcase
    phase_end = tick && phase_last;

    if (blinking && tick) begin
      half_cnt_next = half_last ? '0 : half_cnt + 1'b1;
      if (half_last) led_next = ~led;
    end

    case (state)
      IDLE:  if (start) state_next = SOLID;
      SOLID: if (phase_end) state_next = SLOW;
      SLOW:  if (phase_end) state_next = FAST;
      FAST: begin
        if (phase_end) begin
          done_next  = 1'b1;
          state_next = loop ? SOLID : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Stop outranks start, phase end and the completion pulse.
    if (stop) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end

    // A change of state restarts all phase timing and sets the LED for the new phase.
    if (state_next != state || state_next == IDLE) begin
      tick_cnt_next = '0;
      ms_cnt_next   = '0;
      half_cnt_next = '0;
      led_next      = (state_next != IDLE);
    end else if (state == SOLID) begin
      led_next = 1'b1;
    end

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_led_phase_sequencer.sv
// Directed bench for led_phase_sequencer using small timing parameters.
// Expected phase lengths and LED runs are worked out by hand: 12 / 32 (8-cycle runs) / 16 (4-cycle runs).
module tb_led_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic       led, busy, done;
  logic [1:0] phase;

  int total = 0;
  int bad   = 0;

  led_phase_sequencer #(
    .TICK_DIV(4), .P1_MS(3), .P2_MS(8), .P3_MS(4), .SLOW_HALF(2), .FAST_HALF(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .led(led), .busy(busy), .phase(phase), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Checks len consecutive cycles of one phase. run=0 means the LED stays on solid.
  task automatic run_phase(input string tag, input logic [1:0] ph, input int len,
                           input int run, input logic done_first);
    for (int i = 0; i < len; i++) begin
      logic exp_led;
      exp_led = (run == 0) ? 1'b1 : (((i / run) % 2) == 0);
      check({tag, " phase"}, 32'(phase), 32'(ph));
      check({tag, " led"},   32'(led),   32'(exp_led));
      check({tag, " busy"},  32'(busy),  32'd1);
      check({tag, " done"},  32'(done),  (i == 0) ? 32'(done_first) : 32'd0);
      cycle();
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, " phase"}, 32'(phase), 32'd0);
    check({tag, " led"},   32'(led),   32'd0);
    check({tag, " busy"},  32'(busy),  32'd0);
    check({tag, " done"},  32'(done),  32'(exp_done));
  endtask

  initial begin
    // Power-on reset, applied between clock edges.
    #2 rst = 1'b1;
    #2 check_idle("por", 1'b0);
    #8 rst = 1'b0;
    cycle();
    check_idle("post_por", 1'b0);

    // Single start pulse with loop=0: one full pass, then done in IDLE.
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_phase("p1_solid", 2'd1, 12, 0, 1'b0);
    run_phase("p1_slow",  2'd2, 32, 8, 1'b0);
    run_phase("p1_fast",  2'd3, 16, 4, 1'b0);
    check_idle("p1_end", 1'b1);
    cycle();
    check_idle("p1_after", 1'b0);

    // loop=1: SOLID is re-entered with done on its first cycle, and the second pass keeps the same timing.
    loop  = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_phase("lp_solid", 2'd1, 12, 0, 1'b0);
    run_phase("lp_slow",  2'd2, 32, 8, 1'b0);
    run_phase("lp_fast",  2'd3, 16, 4, 1'b0);
    run_phase("lp_solid2", 2'd1, 12, 0, 1'b1);
    run_phase("lp_slow2",  2'd2, 32, 8, 1'b0);
    loop = 1'b0;
    run_phase("lp_fast2",  2'd3, 16, 4, 1'b0);
    check_idle("lp_end", 1'b1);
    cycle();
    check_idle("lp_after", 1'b0);

    // Stop pulse on the fifth SLOW cycle aborts to IDLE without a done pulse.
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_phase("st_solid", 2'd1, 12, 0, 1'b0);
    run_phase("st_slow",  2'd2, 4, 8, 1'b0);
    check("st_slow5 phase", 32'(phase), 32'd2);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check_idle("st_abort", 1'b0);
    cycle();
    check_idle("st_after", 1'b0);

    // Start held high for a whole pass is ignored while busy, and restarts right after done.
    start = 1'b1;
    cycle();
    run_phase("hd_solid", 2'd1, 12, 0, 1'b0);
    run_phase("hd_slow",  2'd2, 32, 8, 1'b0);
    run_phase("hd_fast",  2'd3, 16, 4, 1'b0);
    check_idle("hd_end", 1'b1);
    cycle();
    // Re-pulse start on the sixth SOLID cycle. Phase lengths must not change.
    start = 1'b0;
    run_phase("rp_solid_a", 2'd1, 5, 0, 1'b0);
    start = 1'b1;
    run_phase("rp_solid_b", 2'd1, 1, 0, 1'b0);
    start = 1'b0;
    run_phase("rp_solid_c", 2'd1, 6, 0, 1'b0);
    run_phase("rp_slow",    2'd2, 32, 8, 1'b0);
    run_phase("rp_fast",    2'd3, 16, 4, 1'b0);
    check_idle("rp_end", 1'b1);
    cycle();

    // Start and stop together in IDLE: the sequencer stays in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    cycle();
    check_idle("ss_same", 1'b0);
    start = 1'b0;
    stop  = 1'b0;
    cycle();
    check_idle("ss_after", 1'b0);

    // Stop on the last FAST cycle with loop=1: goes to IDLE and done stays low.
    loop  = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_phase("sl_solid", 2'd1, 12, 0, 1'b0);
    run_phase("sl_slow",  2'd2, 32, 8, 1'b0);
    run_phase("sl_fast",  2'd3, 15, 4, 1'b0);
    check("sl_last phase", 32'(phase), 32'd3);
    check("sl_last led",   32'(led),   32'd0);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    loop = 1'b0;
    check_idle("sl_abort", 1'b0);
    cycle();
    check_idle("sl_after", 1'b0);

    // Asynchronous reset in the middle of SLOW clears the outputs at once, without waiting for a clock edge.
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_phase("rs_solid", 2'd1, 12, 0, 1'b0);
    run_phase("rs_slow",  2'd2, 10, 8, 1'b0);
    check("rs_pre phase", 32'(phase), 32'd2);
    rst = 1'b1;
    #2 check_idle("rs_async", 1'b0);
    #2 rst = 1'b0;
    cycle();
    check_idle("rs_rel1", 1'b0);
    cycle();
    check_idle("rs_rel2", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
